alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Execution unit that consumes the 4-bit ALU_Operation code produced by the ALU control decoder, i.e. the receiving end of the decoder-to-ALU interface.
- Executes one operation per start handshake. Single-cycle ops finish in 1 cycle; shifts iterate one bit per cycle.
- Returns a registered result, a zero flag and a branch-condition flag to the multi-cycle datapath controller.

Parameters:
DATA_WIDTH, 32, operand/result width
SHAMT_WIDTH, 5, shift-amount bits taken from B (log2 DATA_WIDTH)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
start_i  input  1  request; sampled only when busy_o=0
ALU_Operation_i  input  4  operation code
A_i  input  DATA_WIDTH  operand A (rs1)
B_i  input  DATA_WIDTH  operand B (rs2/immediate); B_i[SHAMT_WIDTH-1:0] is the shift amount
ALU_Result_o  output  DATA_WIDTH  registered result, held until next accepted start
Zero_o  output  1  ALU_Result_o == 0, updated with the result
Branch_o  output  1  branch condition for BEQ/BNE/BLT, 0 for other ops
busy_o  output  1  high while an iterative shift is in progress
done_o  output  1  one-cycle pulse when the result is valid
illegal_op_o  output  1  code 1011-1111 was accepted; held with the result

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Reset: state=IDLE; ALU_Result_o=0, Zero_o=1, Branch_o=0, busy_o=0, done_o=0, illegal_op_o=0, shift counter=0.
- Reset mid-shift: aborts the operation; no done_o pulse follows.
- Opcodes:
  - 0000 ADD: A+B
  - 0001 SUB: A-B
  - 0010 LUI: B
  - 0011 OR
  - 0100 SLL: A<<shamt
  - 0101 SRL: A>>shamt, logical
  - 0110 AND
  - 0111 XOR
  - 1000 BEQ: result A-B, Branch=(A==B)
  - 1001 BNE: result A-B, Branch=(A!=B)
  - 1010 BLT: result A-B, Branch=signed(A)<signed(B)
- Arithmetic: modulo 2^DATA_WIDTH; no carry or overflow outputs.
- States: IDLE, SHIFT.
- IDLE with start_i=1 at edge N:
  - Non-shift op, or shift with shamt=0: result, Zero, Branch, illegal registered at edge N. done_o=1 for the cycle after edge N. Stay in IDLE.
  - Shift with shamt=s>0: latch A into the result register, counter=s, op latched. busy_o=1. Go to SHIFT. Outputs are not valid during busy.
- SHIFT, each edge: shift the result register 1 bit (zero fill), counter-1.
  - On the edge where the counter reaches 0: busy_o=0, done_o=1 for one cycle, Zero_o updated, return to IDLE.
  - Total: done_o visible s cycles after the start edge.
- Inputs A_i/B_i/ALU_Operation_i may change freely after acceptance; the latched copies are used.
- start_i while busy_o=1: ignored, not queued.
- start_i asserted in the done_o cycle: accepted normally (back-to-back). done_o stays a single-cycle pulse per operation.
- Illegal code: ALU_Result_o=0, Zero_o=1, Branch_o=0, illegal_op_o=1, done_o pulses after 1 cycle. illegal_op_o clears on the next accepted start.
- Branch_o and illegal_op_o are held with the result until the next accepted start.

Optional Feature:
- Macro: ALU_SEQ_FAST_SHIFT_EN
- Defined: SLL/SRL use a barrel shifter and finish in 1 cycle like other ops. SHIFT state unused; busy_o stays 0.
- Undefined: iterative 1-bit-per-cycle shifting as above.
- Results are identical in both builds; only latency differs.

Test Plan:
- SUB, A=5, B=7, start for 1 cycle -> next cycle done_o=1, ALU_Result_o=0xFFFFFFFE, Zero_o=0, Branch_o=0.
- SLL, A=1, B=4 -> busy_o high 4 cycles (3 in SHIFT after entry), done_o 4 cycles after start, result=0x00000010. With ALU_SEQ_FAST_SHIFT_EN -> done after 1 cycle.
- SRL, A=0x80000000, B=31 -> done after 31 cycles, result=0x00000001. A start_i pulse with ADD during busy is ignored: no extra done, result unchanged.
- BLT, A=0xFFFFFFFF, B=1 -> Branch_o=1, result=0xFFFFFFFE. BEQ, A=B=0x1234 -> Branch_o=1, Zero_o=1. BNE with the same operands -> Branch_o=0.
- SLL, A=3, B=10; reset asserted 5 cycles after start -> all outputs return to reset values, no done_o; next ADD 2+2 gives 4 after 1 cycle.
- Code 4'b1100, A=9, B=9 -> done_o after 1 cycle, illegal_op_o=1, result=0. Following LUI, B=0xABCDE000 -> result=0xABCDE000, illegal_op_o=0.

Source files
------------

// File: rtl/alu_seq_exec_if.sv
// Decoder-to-ALU handshake bundle: request/operands from the controller, result/flags back.
interface alu_seq_exec_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start_i;
    logic [3:0]            ALU_Operation_i;
    logic [DATA_WIDTH-1:0] A_i;
    logic [DATA_WIDTH-1:0] B_i;
    logic [DATA_WIDTH-1:0] ALU_Result_o;
    logic                  Zero_o;
    logic                  Branch_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  illegal_op_o;

    modport master (
        output start_i, ALU_Operation_i, A_i, B_i,
        input  ALU_Result_o, Zero_o, Branch_o, busy_o, done_o, illegal_op_o
    );

    modport slave (
        input  start_i, ALU_Operation_i, A_i, B_i,
        output ALU_Result_o, Zero_o, Branch_o, busy_o, done_o, illegal_op_o
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Sequential ALU: one op per accepted start, shifts iterate one bit per cycle.
// Define ALU_SEQ_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq_exec #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input logic          clk,
    input logic          reset,
    alu_seq_exec_if.slave bus
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_LUI = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_BLT = 4'b1010;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   branch_q, branch_d;
    logic                   illegal_q, illegal_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   right_q, right_d;

    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  diff;
    logic [DATA_WIDTH-1:0]  shifted;
    logic                   is_shift;
    logic                   accept;
    logic                   iter_start;
    logic                   last_step;
    logic [DATA_WIDTH-1:0]  alu_res;
    logic                   alu_branch;
    logic                   alu_illegal;

    assign shamt     = bus.B_i[SHAMT_WIDTH-1:0];
    assign diff      = bus.A_i - bus.B_i;
    assign is_shift  = (bus.ALU_Operation_i == OP_SLL) || (bus.ALU_Operation_i == OP_SRL);
    assign accept    = (state_q == IDLE) && bus.start_i;
    assign last_step = (cnt_q == SHAMT_WIDTH'(1));
    assign shifted   = right_q ? (result_q >> 1) : (result_q << 1);

`ifdef ALU_SEQ_FAST_SHIFT_EN
    assign iter_start = 1'b0;
`else
    assign iter_start = accept && is_shift && (shamt != '0);
`endif

    // Single-cycle result; in the iterative build a shift only lands here with shamt == 0.
    always_comb begin
        alu_res     = '0;
        alu_branch  = 1'b0;
        alu_illegal = 1'b0;
        case (bus.ALU_Operation_i)
            OP_ADD: alu_res = bus.A_i + bus.B_i;
            OP_SUB: alu_res = diff;
            OP_LUI: alu_res = bus.B_i;
            OP_OR:  alu_res = bus.A_i | bus.B_i;
`ifdef ALU_SEQ_FAST_SHIFT_EN
            OP_SLL: alu_res = bus.A_i << shamt;
            OP_SRL: alu_res = bus.A_i >> shamt;
`else
            OP_SLL: alu_res = bus.A_i;
            OP_SRL: alu_res = bus.A_i;
`endif
            OP_AND: alu_res = bus.A_i & bus.B_i;
            OP_XOR: alu_res = bus.A_i ^ bus.B_i;
            OP_BEQ: begin
                alu_res    = diff;
                alu_branch = (bus.A_i == bus.B_i);
            end
            OP_BNE: begin
                alu_res    = diff;
                alu_branch = (bus.A_i != bus.B_i);
            end
            OP_BLT: begin
                alu_res    = diff;
                alu_branch = ($signed(bus.A_i) < $signed(bus.B_i));
            end
            default: alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iter_start) state_d = SHIFT;
            SHIFT:   if (last_step)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and shift bookkeeping.
    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        right_d   = right_q;
        case (state_q)
            IDLE: begin
                if (iter_start) begin
                    result_d  = bus.A_i;
                    cnt_d     = shamt;
                    right_d   = bus.ALU_Operation_i[0];
                    busy_d    = 1'b1;
                    branch_d  = 1'b0;
                    illegal_d = 1'b0;
                end else if (accept) begin
                    result_d  = alu_res;
                    zero_d    = (alu_res == '0);
                    branch_d  = alu_branch;
                    illegal_d = alu_illegal;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            SHIFT: begin
                result_d = shifted;
                cnt_d    = cnt_q - SHAMT_WIDTH'(1);
                if (last_step) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    zero_d = (shifted == '0);
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            right_q   <= 1'b0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            right_q   <= right_d;
        end
    end

    assign bus.ALU_Result_o = result_q;
    assign bus.Zero_o       = zero_q;
    assign bus.Branch_o     = branch_q;
    assign bus.illegal_op_o = illegal_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed plus randomized bench for alu_seq_exec against an arithmetic reference model.
module tb_alu_seq_exec;

`ifdef ALU_SEQ_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_seq_exec_if #(.DATA_WIDTH(32)) bus ();

    alu_seq_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: result/flags straight from the opcode table; latency in sampled cycles.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic br, output logic ill, output int lat);
        int s;
        s   = int'(b % 32);
        res = 32'h0;
        br  = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0:  res = a + b;
            4'd1:  res = a - b;
            4'd2:  res = b;
            4'd3:  res = a | b;
            4'd4:  begin res = a << s; if (!FAST && s > 0) lat = s + 1; end
            4'd5:  begin res = a >> s; if (!FAST && s > 0) lat = s + 1; end
            4'd6:  res = a & b;
            4'd7:  res = a ^ b;
            4'd8:  begin res = a - b; br = (a == b); end
            4'd9:  begin res = a - b; br = (a != b); end
            4'd10: begin res = a - b; br = ($signed(a) < $signed(b)); end
            default: ill = 1'b1;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [31:0] er, r, rh;
        logic eb, ei, z, br, il;
        int lat, done_at, busy_bad;
        model(op, a, b, er, eb, ei, lat);
        r = 'x; z = 'x; br = 'x; il = 'x; rh = 'x;
        @(negedge clk);
        bus.start_i = 1'b1; bus.ALU_Operation_i = op; bus.A_i = a; bus.B_i = b;
        @(negedge clk);
        bus.start_i = 1'b0; bus.A_i = $urandom; bus.B_i = $urandom; bus.ALU_Operation_i = 4'($urandom);
        done_at = 0;
        busy_bad = 0;
        for (int k = 1; k <= lat + 2; k++) begin
            if (bus.done_o === 1'b1) done_at = (done_at == 0) ? k : -1;
            if (k < lat && bus.busy_o !== 1'b1) busy_bad++;
            if (k >= lat && bus.busy_o !== 1'b0) busy_bad++;
            if (k == lat) begin
                r = bus.ALU_Result_o; z = bus.Zero_o; br = bus.Branch_o; il = bus.illegal_op_o;
            end
            rh = bus.ALU_Result_o;
            if (poke && k == 2 && lat > 3) begin
                bus.start_i = 1'b1; bus.ALU_Operation_i = 4'd0; bus.A_i = 32'd1; bus.B_i = 32'd1;
            end else begin
                bus.start_i = 1'b0;
            end
            if (k < lat + 2) @(negedge clk);
        end
        chk({tag, "_done_cycle"}, 32'(done_at), 32'(lat));
        chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
        chk({tag, "_result"}, r, er);
        chk({tag, "_zero"}, {31'd0, z}, {31'd0, er == 32'd0});
        chk({tag, "_branch"}, {31'd0, br}, {31'd0, eb});
        chk({tag, "_illegal"}, {31'd0, il}, {31'd0, ei});
        chk({tag, "_held"}, rh, er);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [3:0] op;
        int nd;
        reset = 1'b1;
        bus.start_i = 1'b0; bus.ALU_Operation_i = 4'd0; bus.A_i = '0; bus.B_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", bus.ALU_Result_o, 32'h0);
        chk("rst_flags", {26'd0, bus.Zero_o, bus.Branch_o, bus.busy_o, bus.done_o, bus.illegal_op_o, 1'b0},
            {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;

        run_op("sub", 4'd1, 32'd5, 32'd7, 1'b0);
        run_op("sll", 4'd4, 32'd1, 32'd4, 1'b0);
        chk("sll_value", bus.ALU_Result_o, 32'h10);
        run_op("srl_poke", 4'd5, 32'h8000_0000, 32'd31, 1'b1);
        chk("srl_value", bus.ALU_Result_o, 32'h1);
        run_op("blt", 4'd10, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("beq", 4'd8, 32'h1234, 32'h1234, 1'b0);
        chk("beq_branch", {31'd0, bus.Branch_o}, 32'd1);
        run_op("bne", 4'd9, 32'h1234, 32'h1234, 1'b0);
        run_op("sll0", 4'd4, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 1'b0);

        // Reset five cycles into a long shift.
        @(negedge clk);
        bus.start_i = 1'b1; bus.ALU_Operation_i = 4'd4; bus.A_i = 32'd3; bus.B_i = 32'd10;
        @(negedge clk);
        bus.start_i = 1'b0;
        nd = 0;
        for (int k = 1; k <= 5; k++) begin
            if (bus.done_o === 1'b1) nd++;
            if (k == 5) chk("abort_busy", {31'd0, bus.busy_o}, {31'd0, !FAST});
            if (k < 5) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_result", bus.ALU_Result_o, 32'h0);
        chk("abort_flags", {27'd0, bus.Zero_o, bus.Branch_o, bus.busy_o, bus.done_o, bus.illegal_op_o},
            {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'(FAST));
        run_op("add_after_abort", 4'd0, 32'd2, 32'd2, 1'b0);
        chk("add_value", bus.ALU_Result_o, 32'd4);

        run_op("illegal", 4'b1100, 32'd9, 32'd9, 1'b0);
        run_op("lui", 4'd2, 32'd0, 32'hABCD_E000, 1'b0);

        // Back-to-back: second start issued in the done cycle of the first.
        @(negedge clk);
        bus.start_i = 1'b1; bus.ALU_Operation_i = 4'd0; bus.A_i = 32'd1; bus.B_i = 32'd2;
        @(negedge clk);
        chk("b2b_first_done", {31'd0, bus.done_o}, 32'd1);
        chk("b2b_first_res", bus.ALU_Result_o, 32'd3);
        bus.ALU_Operation_i = 4'd1; bus.A_i = 32'd10; bus.B_i = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("b2b_second_done", {31'd0, bus.done_o}, 32'd1);
        chk("b2b_second_res", bus.ALU_Result_o, 32'd7);
        @(negedge clk);
        chk("b2b_pulse_end", {31'd0, bus.done_o}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 0) b = b & 32'h7;
            if (i % 5 == 0) b = a;
            run_op("rand", op, a, b, (i % 3 == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
